// File: rtl/adjust_key_ctrl.sv
// adjust_key_ctrl: conditions the four DE2 push-buttons into the adjust/select/add/clr
// controls for time_float. The key path is synchronise, invert, debounce and then a
// one-cycle press event. A mode toggle drives adjust and blink. A digit-select counter
// can defer one increment. A shared add/clr pulse generator has a low guard after each
// pulse, and holding KEY2 auto-repeats add.
module adjust_key_ctrl #(
    parameter int DEBOUNCE_CYC  = 1_000_000,
    parameter int PULSE_CYC     = 16,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int BLINK_CYC     = 12_500_000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic [3:0] KEY,
    output logic       adjust,
    output logic [3:0] select,
    output logic       add,
    output logic       clr,
    output logic       blink
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int PL_W  = $clog2(PULSE_CYC + 1);
    localparam int RP_MX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W  = $clog2(RP_MX + 1);
    localparam int BL_W  = $clog2(BLINK_CYC + 1);

    localparam logic [1:0] P_IDLE   = 2'd0;
    localparam logic [1:0] P_HIGH   = 2'd1;
    localparam logic [1:0] P_GUARD  = 2'd2;
    localparam logic [1:0] R_REL    = 2'd0;
    localparam logic [1:0] R_DELAY  = 2'd1;
    localparam logic [1:0] R_REPEAT = 2'd2;

    logic [3:0]      sync1_q, sync2_q, pressed_s;
    logic [3:0]      stable_q, stable_d, evt_q, evt_d;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];
    logic            adjust_q, adjust_d, blink_q, blink_d;
    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
    logic [1:0]      rep_state_q, rep_state_d, pls_state_q, pls_state_d;
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [PL_W-1:0] pls_cnt_q, pls_cnt_d;
    logic            add_q, add_d, clr_q, clr_d, req_add_s, req_clr_s;
    logic [3:0]      select_q, select_d;
    logic            pend_q, pend_d, sel_evt_s;

    assign pressed_s = ~sync2_q;
    assign req_clr_s = evt_q[3] & ~adjust_q;
    assign sel_evt_s = evt_q[1] & ~adjust_q;

    // Per-key debounce: count while the synced level disagrees with the stable level
    always_comb begin
        stable_d = stable_q;
        evt_d    = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (pressed_s[k] != stable_q[k]) begin
                if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    stable_d[k] = pressed_s[k];
                    evt_d[k]    = pressed_s[k];
                    db_cnt_d[k] = {DB_W{1'b0}};
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
                end
            end else begin
                db_cnt_d[k] = {DB_W{1'b0}};
            end
        end
    end

    // Mode toggle and blink: blink restarts high with a cleared counter on entry to set mode
    always_comb begin
        adjust_d = adjust_q ^ evt_q[0];
        blink_d  = blink_q;
        bl_cnt_d = bl_cnt_q;
        if (adjust_d == 1'b0) begin
            if (adjust_q == 1'b1) begin
                blink_d  = 1'b1;
                bl_cnt_d = {BL_W{1'b0}};
            end else if (bl_cnt_q == BL_W'(BLINK_CYC - 1)) begin
                blink_d  = ~blink_q;
                bl_cnt_d = {BL_W{1'b0}};
            end else begin
                bl_cnt_d = bl_cnt_q + BL_W'(1);
            end
        end else begin
            blink_d  = 1'b0;
            bl_cnt_d = {BL_W{1'b0}};
        end
    end

    // Add auto-repeat: first add on the press, one after the hold delay, then periodic
    always_comb begin
        rep_state_d = rep_state_q;
        rep_cnt_d   = rep_cnt_q;
        req_add_s   = 1'b0;
        case (rep_state_q)
            R_REL: begin
                rep_cnt_d = {RP_W{1'b0}};
                if (evt_q[2] && !adjust_q) begin
                    req_add_s   = 1'b1;
                    rep_state_d = R_DELAY;
                end else begin
                    rep_state_d = R_REL;
                end
            end
            R_DELAY, R_REPEAT: begin
                if (!stable_q[2] || adjust_q) begin
                    rep_state_d = R_REL;
                    rep_cnt_d   = {RP_W{1'b0}};
                end else if ((rep_state_q == R_DELAY  && rep_cnt_q == RP_W'(REPEAT_DELAY - 1)) ||
                             (rep_state_q == R_REPEAT && rep_cnt_q == RP_W'(REPEAT_PERIOD - 1))) begin
                    rep_state_d = R_REPEAT;
                    rep_cnt_d   = {RP_W{1'b0}};
                    req_add_s   = 1'b1;
                end else begin
                    rep_cnt_d   = rep_cnt_q + RP_W'(1);
                end
            end
            default: begin
                rep_state_d = R_REL;
                rep_cnt_d   = {RP_W{1'b0}};
            end
        endcase
    end

    // Shared pulse generator: clr beats add, nothing accepted outside IDLE or in run mode
    always_comb begin
        pls_state_d = pls_state_q;
        pls_cnt_d   = pls_cnt_q;
        add_d       = add_q;
        clr_d       = clr_q;
        case (pls_state_q)
            P_IDLE: begin
                pls_cnt_d = {PL_W{1'b0}};
                if (!adjust_q && req_clr_s) begin
                    pls_state_d = P_HIGH;
                    clr_d       = 1'b1;
                end else if (!adjust_q && req_add_s) begin
                    pls_state_d = P_HIGH;
                    add_d       = 1'b1;
                end else begin
                    pls_state_d = P_IDLE;
                end
            end
            P_HIGH: begin
                if (pls_cnt_q == PL_W'(PULSE_CYC - 1)) begin
                    pls_state_d = P_GUARD;
                    pls_cnt_d   = {PL_W{1'b0}};
                    add_d       = 1'b0;
                    clr_d       = 1'b0;
                end else begin
                    pls_cnt_d   = pls_cnt_q + PL_W'(1);
                end
            end
            P_GUARD: begin
                if (pls_cnt_q == PL_W'(PULSE_CYC - 1)) begin
                    pls_state_d = P_IDLE;
                    pls_cnt_d   = {PL_W{1'b0}};
                end else begin
                    pls_cnt_d   = pls_cnt_q + PL_W'(1);
                end
            end
            default: begin
                pls_state_d = P_IDLE;
                pls_cnt_d   = {PL_W{1'b0}};
                add_d       = 1'b0;
                clr_d       = 1'b0;
            end
        endcase
    end

    // Digit select: frozen during a pulse, with at most one deferred increment
    always_comb begin
        select_d = select_q;
        pend_d   = pend_q;
        if (pls_state_q == P_IDLE) begin
            if (pend_q || sel_evt_s) begin
                select_d = select_q + 4'd1;
            end else begin
                select_d = select_q;
            end
            pend_d = 1'b0;
        end else begin
            if (sel_evt_s) begin
                pend_d = 1'b1;
            end else begin
                pend_d = pend_q;
            end
        end
    end

    // State registers with synchronous reset; raw keys reset to the released level
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            stable_q    <= 4'h0;
            evt_q       <= 4'h0;
            for (int k = 0; k < 4; k++) db_cnt_q[k] <= {DB_W{1'b0}};
            adjust_q    <= 1'b1;
            blink_q     <= 1'b0;
            bl_cnt_q    <= {BL_W{1'b0}};
            rep_state_q <= R_REL;
            rep_cnt_q   <= {RP_W{1'b0}};
            pls_state_q <= P_IDLE;
            pls_cnt_q   <= {PL_W{1'b0}};
            add_q       <= 1'b0;
            clr_q       <= 1'b0;
            select_q    <= 4'h0;
            pend_q      <= 1'b0;
        end else begin
            sync1_q     <= KEY;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            evt_q       <= evt_d;
            for (int k = 0; k < 4; k++) db_cnt_q[k] <= db_cnt_d[k];
            adjust_q    <= adjust_d;
            blink_q     <= blink_d;
            bl_cnt_q    <= bl_cnt_d;
            rep_state_q <= rep_state_d;
            rep_cnt_q   <= rep_cnt_d;
            pls_state_q <= pls_state_d;
            pls_cnt_q   <= pls_cnt_d;
            add_q       <= add_d;
            clr_q       <= clr_d;
            select_q    <= select_d;
            pend_q      <= pend_d;
        end
    end

    assign adjust = adjust_q;
    assign select = select_q;
    assign add    = add_q;
    assign clr    = clr_q;
    assign blink  = blink_q;
endmodule

// File: tb/tb_adjust_key_ctrl.sv
// Scoreboard bench for adjust_key_ctrl with short simulation parameters.
module tb_adjust_key_ctrl;
    localparam int PULSE = 4;

    typedef struct { logic [3:0] val; int cyc; } chg_t;
    typedef struct { int cyc; int width; } pls_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic       adjust, add, clr, blink;
    logic [3:0] select;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit blink_chk = 1'b0;

    chg_t adj_q[$], sel_q[$], blk_q[$];
    pls_t add_q[$], clr_q[$];
    logic [7:0] snap_q[$];

    logic       adj_prev, add_prev, clr_prev, blk_prev;
    logic [3:0] sel_prev;
    int add_rise, clr_rise, add_w_exp, clr_w_exp;
    int last_fall = -1;

    adjust_key_ctrl #(
        .DEBOUNCE_CYC(8), .PULSE_CYC(4), .REPEAT_DELAY(64),
        .REPEAT_PERIOD(32), .BLINK_CYC(16)
    ) dut (
        .CLOCK_50(clk), .rst(rst), .KEY(key),
        .adjust(adjust), .select(select), .add(add), .clr(clr), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_chg(input string nm, input logic [3:0] got, input bit have, input chg_t e);
        tests++;
        if (!have) begin
            fails++;
            $display("FAIL %s: changed to %0d at cycle %0d, required no change", nm, got, cyc);
        end else if (got !== e.val || cyc != e.cyc) begin
            fails++;
            $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d", nm, got, cyc, e.val, e.cyc);
        end
    endtask

    task automatic chk_rise(input string nm, input bit have, input pls_t p, output int w_exp);
        tests++;
        w_exp = have ? p.width : PULSE;
        if (!have) begin
            fails++;
            $display("FAIL %s_rise: pulse at cycle %0d, required none", nm, cyc);
        end else if (cyc != p.cyc) begin
            fails++;
            $display("FAIL %s_rise: pulse at cycle %0d, required cycle %0d", nm, cyc, p.cyc);
        end
        if (last_fall >= 0) begin
            tests++;
            if (cyc - last_fall < PULSE) begin
                fails++;
                $display("FAIL %s_guard: low gap %0d, required >= %0d", nm, cyc - last_fall, PULSE);
            end
        end
    endtask

    task automatic chk_fall(input string nm, input int rise, input int w_exp);
        tests++;
        if (cyc - rise != w_exp) begin
            fails++;
            $display("FAIL %s_width: high %0d cycles, required %0d", nm, cyc - rise, w_exp);
        end
        last_fall = cyc;
    endtask

    // Monitor: every output change pops its queue; snapshots compare the whole output set
    always @(negedge clk) begin
        chg_t e;
        pls_t p;
        bit   have;
        logic [7:0] s;
        if (mon_en) begin
            if (adjust !== adj_prev) begin
                have = adj_q.size() > 0;
                if (have) e = adj_q.pop_front();
                chk_chg("adjust", {3'b000, adjust}, have, e);
            end
            if (select !== sel_prev) begin
                have = sel_q.size() > 0;
                if (have) e = sel_q.pop_front();
                chk_chg("select", select, have, e);
            end
            if (blink_chk && blink !== blk_prev) begin
                have = blk_q.size() > 0;
                if (have) e = blk_q.pop_front();
                chk_chg("blink", {3'b000, blink}, have, e);
            end
            if (add === 1'b1 && add_prev !== 1'b1) begin
                have = add_q.size() > 0;
                if (have) p = add_q.pop_front();
                chk_rise("add", have, p, add_w_exp);
                add_rise = cyc;
            end
            if (add === 1'b0 && add_prev === 1'b1) chk_fall("add", add_rise, add_w_exp);
            if (clr === 1'b1 && clr_prev !== 1'b1) begin
                have = clr_q.size() > 0;
                if (have) p = clr_q.pop_front();
                chk_rise("clr", have, p, clr_w_exp);
                clr_rise = cyc;
            end
            if (clr === 1'b0 && clr_prev === 1'b1) chk_fall("clr", clr_rise, clr_w_exp);
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                tests++;
                if ({adjust, select, add, clr, blink} !== s) begin
                    fails++;
                    $display("FAIL snapshot: {adjust,select,add,clr,blink} got %b, required %b at cycle %0d",
                             {adjust, select, add, clr, blink}, s, cyc);
                end
            end
        end
        adj_prev <= adjust;
        sel_prev <= select;
        blk_prev <= blink;
        add_prev <= add;
        clr_prev <= clr;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key_down(input int k, output int n);
        @(negedge clk);
        key[k] = 1'b0;
        n = cyc;
    endtask

    task automatic key_up(input int k);
        @(negedge clk);
        key[k] = 1'b1;
    endtask

    task automatic leftover(input string nm, input int sz);
        tests++;
        if (sz != 0) begin
            fails++;
            $display("FAIL %s_pending: %0d expected events never seen, required 0", nm, sz);
        end
    endtask

    initial begin
        int n, m, n1;
        tick(5);
        rst = 1'b0;
        mon_en = 1'b1;
        snap_q.push_back({1'b1, 4'd0, 1'b0, 1'b0, 1'b0});
        tick(3);

        // Bouncing KEY0 then steady low: a single toggle into set mode
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            key[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        key_down(0, n);
        adj_q.push_back('{4'd0, n + 11});
        tick(20);
        key_up(0);
        tick(14);

        // Sixteen KEY1 presses in set mode: select walks 1..15 and wraps to 0
        for (int j = 1; j <= 16; j++) begin
            key_down(1, n);
            sel_q.push_back('{4'(j % 16), n + 11});
            tick(12);
            key_up(1);
            tick(12);
        end

        // Run mode: KEY1 ignored
        key_down(0, n);
        adj_q.push_back('{4'd1, n + 11});
        tick(14);
        key_up(0);
        tick(14);
        key_down(1, n);
        tick(14);
        key_up(1);
        tick(14);
        snap_q.push_back({1'b1, 4'd0, 1'b0, 1'b0, 1'b0});
        tick(2);

        // Back to set mode
        key_down(0, n);
        adj_q.push_back('{4'd0, n + 11});
        tick(14);
        key_up(0);
        tick(14);

        // Held KEY2: first add at debounce, +64, then every 32
        key_down(2, n);
        add_q.push_back('{n + 11, PULSE});
        add_q.push_back('{n + 75, PULSE});
        add_q.push_back('{n + 107, PULSE});
        add_q.push_back('{n + 139, PULSE});
        tick(149);
        key_up(2);
        tick(20);

        // KEY2 and KEY3 in the same cycle: only clr
        @(negedge clk);
        key[3:2] = 2'b00;
        n = cyc;
        clr_q.push_back('{n + 11, PULSE});
        tick(20);
        @(negedge clk);
        key[3:2] = 2'b11;
        tick(20);

        // KEY1 during a clr pulse: increment deferred until after the guard
        key_down(3, n);
        tick(2);
        key_down(1, n1);
        clr_q.push_back('{n + 11, PULSE});
        sel_q.push_back('{4'd1, n + 20});
        tick(14);
        key_up(3);
        key_up(1);
        tick(20);

        // Reset during add HIGH: pulse cut, defaults restored, held key gives no pulse
        key_down(2, n);
        add_q.push_back('{n + 11, 2});
        adj_q.push_back('{4'd1, n + 13});
        sel_q.push_back('{4'd0, n + 13});
        while (cyc < n + 12) @(negedge clk);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(60);
        key_up(2);
        tick(20);
        snap_q.push_back({1'b1, 4'd0, 1'b0, 1'b0, 1'b0});
        tick(2);

        // Blink in set mode, then back to run mode with blink low and no pulses
        key_down(0, n);
        blink_chk = 1'b1;
        adj_q.push_back('{4'd0, n + 11});
        blk_q.push_back('{4'd1, n + 11});
        blk_q.push_back('{4'd0, n + 27});
        blk_q.push_back('{4'd1, n + 43});
        blk_q.push_back('{4'd0, n + 59});
        blk_q.push_back('{4'd1, n + 75});
        while (cyc < n + 20) @(negedge clk);
        key_up(0);
        while (cyc < n + 69) @(negedge clk);
        key_down(0, m);
        adj_q.push_back('{4'd1, m + 11});
        blk_q.push_back('{4'd0, m + 11});
        tick(20);
        key_up(0);
        tick(40);
        blink_chk = 1'b0;
        snap_q.push_back({1'b1, 4'd0, 1'b0, 1'b0, 1'b0});
        tick(3);

        leftover("adjust", adj_q.size());
        leftover("select", sel_q.size());
        leftover("blink", blk_q.size());
        leftover("add", add_q.size());
        leftover("clr", clr_q.size());
        leftover("snapshot", snap_q.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
